// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared types for the seven-segment scan controller: FSM state encoding
// and the per-digit nibble extraction helper.
package sevenseg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam int MAX_DIGITS = 16;
  typedef logic [4*MAX_DIGITS-1:0] digits_t;

  // Digit k occupies bits [4k+3:4k]; callers zero-extend their vector to digits_t.
  function automatic logic [3:0] digit_field(input digits_t vals, input int k);
    return vals[4*k +: 4];
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Host-side bundle of the scan controller: value loading, scan enable and
// the registered drive towards the shared decoder and digit transistors.
interface sevenseg_scan_ctrl_if #(parameter int NDIGITS = 4);
  logic                   enable;
  logic                   load;
  logic [4*NDIGITS-1:0]   data_in;
  logic [NDIGITS-1:0]     dp_in;
  logic [3:0]             nibble;
  logic                   dp;
  logic [NDIGITS-1:0]     digit_en;
  logic                   frame_done;
  logic                   upd_done;

  modport master (
    output enable, load, data_in, dp_in,
    input  nibble, dp, digit_en, frame_done, upd_done
  );

  modport slave (
    input  enable, load, data_in, dp_in,
    output nibble, dp, digit_en, frame_done, upd_done
  );
endinterface

// File: rtl/sevenseg_scan_ctrl_scan_timer.sv
// Loadable down-counter that paces the blank and show phases; it parks at
// zero and reports it until reloaded.
module scan_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reload,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (reload)           cnt <= value;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller: double-buffered digit values, blank gap
// before each digit, value updates applied only at frame boundaries.
module sevenseg_scan_ctrl #(
  parameter int NDIGITS = 4,
  parameter int DIV     = 1000,
  parameter int BLANK   = 2
) (
  input  logic                clk,
  input  logic                reset,
  sevenseg_scan_ctrl_if.slave bus
);
  import sevenseg_pkg::*;

  localparam int SPAN = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int IW   = $clog2(NDIGITS);
  localparam logic [CW-1:0] DIV_LD   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);

  state_t               state;
  logic [IW-1:0]        idx, next_idx;
  logic                 last, boundary;
  logic [4*NDIGITS-1:0] pending_val, active_val, show_val;
  logic [NDIGITS-1:0]   pending_dp, active_dp, show_dp;
  logic                 pending_valid;
  logic                 t_reload, t_zero;
  logic [CW-1:0]        t_value;

  scan_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .reload(t_reload),
    .value (t_value),
    .en    (bus.enable),
    .zero  (t_zero)
  );

  assign last     = (idx == IW'(NDIGITS - 1));
  assign next_idx = last ? '0 : idx + 1'b1;
  assign boundary = bus.enable &&
                    (state == sevenseg_pkg::IDLE ||
                     (state == sevenseg_pkg::SHOW && t_zero && last));
  // Data presented on entry to a new frame is the freshly transferred pending copy.
  assign show_val = (boundary && pending_valid) ? pending_val : active_val;
  assign show_dp  = (boundary && pending_valid) ? pending_dp  : active_dp;

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    t_reload = 1'b1;
    t_value  = '0;
    if (bus.enable) begin
      unique case (state)
        sevenseg_pkg::IDLE:  t_value = BLANK_LD;
        sevenseg_pkg::BLANK: begin t_reload = t_zero; t_value = DIV_LD;   end
        sevenseg_pkg::SHOW:  begin t_reload = t_zero; t_value = BLANK_LD; end
        default: ;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the buffers are plain flops, so they take the reset like any other register.
      state          <= sevenseg_pkg::IDLE;
      idx            <= '0;
      pending_val    <= '0;
      pending_dp     <= '0;
      active_val     <= '0;
      active_dp      <= '0;
      pending_valid  <= 1'b0;
      bus.nibble     <= '0;
      bus.dp         <= 1'b0;
      bus.digit_en   <= '0;
      bus.frame_done <= 1'b0;
      bus.upd_done   <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.upd_done   <= 1'b0;

      if (boundary && pending_valid) begin
        active_val   <= pending_val;
        active_dp    <= pending_dp;
        bus.upd_done <= 1'b1;
      end
      // A load coinciding with a transfer refills pending and keeps it valid.
      if (bus.load) begin
        pending_val   <= bus.data_in;
        pending_dp    <= bus.dp_in;
        pending_valid <= 1'b1;
      end else if (boundary) begin
        pending_valid <= 1'b0;
      end

      if (!bus.enable) begin
        state        <= sevenseg_pkg::IDLE;
        idx          <= '0;
        bus.nibble   <= '0;
        bus.dp       <= 1'b0;
        bus.digit_en <= '0;
      end else begin
        unique case (state)
          sevenseg_pkg::IDLE: begin
            state        <= sevenseg_pkg::BLANK;
            idx          <= '0;
            bus.nibble   <= digit_field(digits_t'(show_val), 0);
            bus.dp       <= show_dp[0];
            bus.digit_en <= '0;
          end
          sevenseg_pkg::BLANK: begin
            if (t_zero) begin
              state        <= sevenseg_pkg::SHOW;
              bus.digit_en <= NDIGITS'(1) << idx;
            end
          end
          sevenseg_pkg::SHOW: begin
            if (t_zero) begin
              state          <= sevenseg_pkg::BLANK;
              idx            <= next_idx;
              bus.digit_en   <= '0;
              bus.nibble     <= digit_field(digits_t'(show_val), int'(next_idx));
              bus.dp         <= show_dp[next_idx];
              bus.frame_done <= last;
            end
          end
          default: state <= sevenseg_pkg::IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a position-based display model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_sevenseg_scan_ctrl;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int B  = 1;
  localparam int DP = B + D;
  localparam int FP = N * DP;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sevenseg_scan_ctrl_if #(.NDIGITS(N)) bus();

  sevenseg_scan_ctrl #(.NDIGITS(N), .DIV(D), .BLANK(B)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]   nibble;
    logic         dp;
    logic [N-1:0] en;
    logic         fd;
    logic         ud;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: digit values as plain arrays, scan position as a cycle count.
  int act_d[N], pend_d[N];
  bit act_p[N], pend_p[N];
  bit pv, running;
  int pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit en, input bit ld,
                      input logic [4*N-1:0] d, input logic [N-1:0] p);
    obs_t e;
    bit   bnd, wrap, upd;
    int   dig;
    @(negedge clk); #1;
    reset = r; bus.enable = en; bus.load = ld; bus.data_in = d; bus.dp_in = p;
    e = '0;
    if (r) begin
      running = 0; pos = 0; pv = 0;
      for (int k = 0; k < N; k++) begin
        act_d[k] = 0; pend_d[k] = 0; act_p[k] = 0; pend_p[k] = 0;
      end
    end else begin
      bnd = 0; wrap = 0; upd = 0;
      if (!en) running = 0;
      else if (!running) begin running = 1; pos = 0; bnd = 1; end
      else begin
        pos++;
        if (pos == FP) begin pos = 0; bnd = 1; wrap = 1; end
      end
      if (bnd && pv) begin
        act_d = pend_d; act_p = pend_p; upd = 1; pv = 0;
      end
      if (ld) begin
        for (int k = 0; k < N; k++) begin
          pend_d[k] = int'(d[4*k +: 4]);
          pend_p[k] = p[k];
        end
        pv = 1;
      end
      if (running) begin
        dig      = pos / DP;
        e.nibble = 4'(act_d[dig]);
        e.dp     = act_p[dig];
        if (pos % DP >= B) e.en = N'(1) << dig;
      end
      e.fd = wrap;
      e.ud = upd;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("nibble",     32'(bus.nibble),     32'(e.nibble));
      check("dp",         32'(bus.dp),         32'(e.dp));
      check("digit_en",   32'(bus.digit_en),   32'(e.en));
      check("frame_done", 32'(bus.frame_done), 32'(e.fd));
      check("upd_done",   32'(bus.upd_done),   32'(e.ud));
      check("onehot0",    32'($onehot0(bus.digit_en)), 32'd1);
    end
  end

  initial begin
    reset = 1'b1; bus.enable = 1'b0; bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0;
    running = 0; pos = 0; pv = 0;
    for (int k = 0; k < N; k++) begin
      act_d[k] = 0; pend_d[k] = 0; act_p[k] = 0; pend_p[k] = 0;
    end

    // Reset held with enable high, then the first scan entry.
    repeat (3) step(1'b1, 1'b1, 1'b0, '0, '0);
    run(8);

    // Load while idle, then display 1,2,3,4 with dp on digit 1.
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 16'h4321, 4'b0010);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    run(2 * FP);

    // Two mid-frame loads: only the last one is shown, one upd_done.
    run(3);
    step(1'b0, 1'b1, 1'b1, 16'hAAAA, 4'b1111);
    run(4);
    step(1'b0, 1'b1, 1'b1, 16'h5678, 4'b0001);
    run(2 * FP);

    // Load on the exact boundary edge: older pending shows first.
    step(1'b0, 1'b1, 1'b1, 16'h1111, 4'b0100);
    for (int i = 0; i < FP + 2 && !(running && pos == FP - 1); i++) run(1);
    step(1'b0, 1'b1, 1'b1, 16'h9999, 4'b1000);
    run(2 * FP + 2);

    // Drop enable in the middle of digit 2's show phase, then restart.
    for (int i = 0; i < FP + 2 && !(running && pos == 2 * DP + B + 1); i++) run(1);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);
    run(FP + 5);

    // Random traffic: occasional reset, enable drops and loads.
    repeat (400) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom));
    end

    // Free run for three full frames.
    run(3 * FP + 2);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexing scan controller for a shared seven-segment decoder driving an NDIGITS common-cathode display. It holds a double-buffered digit value register, walks the digits in sequence, and presents one 4-bit nibble at a time to the existing `sevensegment` decoder, whose A..D inputs are nibble[3..0]. A blanking gap precedes every digit to suppress ghosting. New display values are accepted at any time and take effect only at a frame boundary.

## Interface
- NDIGITS, 4: number of digits scanned; at least 2.
- DIV, 1000: clk cycles each digit is lit; at least 1.
- BLANK, 2: clk cycles of blanking before each digit; at least 1.

- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high; the only reset.
- enable  in  1  scan enable; low forces IDLE.
- load  in  1  single-cycle strobe that captures data_in and dp_in into the pending buffer.
- data_in  in  4*NDIGITS  digit values; digit k is data_in[4k+3:4k].
- dp_in  in  NDIGITS  decimal-point per digit.
- nibble  out  4  value sent to the decoder; nibble[3]=A, nibble[0]=D.
- dp  out  1  decimal point for the current digit.
- digit_en  out  NDIGITS  one-hot digit drive, active-high; all zero while blanking or idle.
- frame_done  out  1  one-cycle pulse at each frame wrap.
- upd_done  out  1  one-cycle pulse when pending values are transferred to active.

## Operation
- Two buffers, pending and active, each holding 4*NDIGITS value bits plus NDIGITS dp bits, and a pending_valid flag.
- load=1 writes pending and sets pending_valid. A second load before transfer overwrites pending; the last write wins.
- FSM states IDLE, BLANK, SHOW; the digit index idx runs 0..NDIGITS-1.
  - IDLE: outputs low, idx=0. If enable=1, go to BLANK next cycle.
  - BLANK: lasts BLANK cycles. digit_en is all zero. nibble and dp already show active[idx]. Go to SHOW.
  - SHOW: lasts DIV cycles. digit_en[idx]=1. Then go to BLANK with idx+1. If idx is NDIGITS-1, idx wraps to 0.
- Frame boundary is every entry into BLANK with idx=0, including the first entry from IDLE.
  - If pending_valid=1 at the boundary, pending is copied to active, pending_valid is cleared, and upd_done pulses.
  - frame_done pulses only on a wrap from SHOW, never on the first entry from IDLE.
- A load in the same cycle as a transfer captures the new data into pending and leaves pending_valid set. The transfer moves the old pending contents.
- enable=0 in any state sends the FSM to IDLE on the next edge, clearing idx and the counter. Buffers are kept.
- reset mid-scan behaves as enable=0 and also clears both buffers and pending_valid.
- The block does no decode. Values 0xA..0xF pass through unchanged.

## Timing
- All outputs are registered.
- Reset values: nibble=0, dp=0, digit_en=0, frame_done=0, upd_done=0, state IDLE, active=0, pending=0.
- enable rises at cycle t. BLANK starts at t+1. digit_en[0] rises at t+1+BLANK.
- Digit period is BLANK+DIV cycles; frame period is NDIGITS*(BLANK+DIV).
- frame_done and upd_done assert in the first BLANK cycle of the new frame, together with the new nibble.
- A load at cycle c appears on nibble no later than one frame period plus one cycle after c.
- The counter width is $clog2(max(DIV,BLANK)). It counts down to 0, then reloads.

## Structure
- sevenseg_pkg holds:
  - the state typedef: enum logic [1:0] {IDLE, BLANK, SHOW};
  - the field-extraction helper function for digit k.
- One sub-module, scan_timer, is the loadable down-counter. It takes reload, value and en, and reports zero.
- The `sevensegment` decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios use NDIGITS=4, DIV=4, BLANK=1.
- Reset with enable=1: all outputs are 0 while reset is high. The first BLANK starts 1 cycle after reset falls. No frame_done pulses on that first entry.
- load data_in=16'h4321, dp_in=4'b0010, then hold enable: upd_done pulses at the first boundary. nibble sequence is 1,2,3,4. digit_en follows 0001,0010,0100,1000, each for 4 cycles after 1 blank cycle. dp=1 only while digit_en=0010.
- Two loads mid-frame (16'hAAAA, then 16'h5678): the next frame shows 8,7,6,5. upd_done pulses exactly once.
- Load on the exact boundary cycle: the old pending value displays, pending_valid stays 1, and the new value appears one frame later.
- Drop enable mid-SHOW on digit 2: digit_en goes to 0 the next cycle. Re-enabling restarts at digit 0 with the same active values.
- Free-run for 3 frames: frame_done pulses every 20 cycles, and digit_en is never multi-hot.
